// File: rtl/clock_gen.sv
// Multi-channel clock divider. Each channel produces a 50% duty square wave with a
// runtime-loadable half-period, a per-channel enable with glitch-free stop, and (channel 0
// only) a single-step mode that emits exactly one period per step_req rising edge.
module clock_gen #(
  parameter int unsigned             NUM_CH    = 2,
  parameter int unsigned             CNT_W     = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_RESET = {32'd50000, 32'd5000000}
) (
  input  logic                    clk_board,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*CNT_W-1:0] div_value,
  input  logic                    step_mode,
  input  logic                    step_req,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*CNT_W-1:0] div_active
);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStopping,
    StStepHi,
    StStepLo
  } ch_state_e;

  logic step_q;
  logic step_rise;

  assign step_rise = step_req & ~step_q;

  // step_req edge detector shared by channel 0
  always_ff @(posedge clk_board) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_req;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             clk_q;
    logic             tick_q;

    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] h_eff;
    logic             at_limit;
    logic             step_sel;
    logic             run_ok;
    logic             half_done;

    assign load_val = div_value[i*CNT_W +: CNT_W];
    // A zero half-period behaves as one cycle
    assign h_eff    = (div_q == '0) ? CNT_W'(1) : div_q;
    assign at_limit = (cnt_q == h_eff - CNT_W'(1));
    assign step_sel = (i == 0) ? step_mode : 1'b0;
    assign run_ok   = ch_en[i] & ~step_sel;

    // A half-period completes here; a low-phase stop in RUN is not a completion
    always_comb begin
      half_done = 1'b0;
      unique case (state_q)
        StRun:                          half_done = at_limit & (run_ok | clk_q);
        StStopping, StStepHi, StStepLo: half_done = at_limit;
        default:                        half_done = 1'b0;
      endcase
    end

    // Channel FSM, counter, divisor pipeline and registered outputs
    always_ff @(posedge clk_board) begin
      if (rst) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        div_q      <= DIV_RESET[i*CNT_W +: CNT_W];
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;

        // New divisor takes effect only between half-periods (or while idle)
        if (state_q == StIdle) begin
          if (pend_vld_q) begin
            div_q <= pend_q;
          end
          pend_vld_q <= 1'b0;
        end else if (half_done) begin
          if (div_load[i]) begin
            div_q <= load_val;
          end else if (pend_vld_q) begin
            div_q <= pend_q;
          end
          pend_vld_q <= 1'b0;
        end
        if (div_load[i] && !half_done) begin
          pend_q     <= load_val;
          pend_vld_q <= 1'b1;
        end

        unique case (state_q)
          StIdle: begin
            cnt_q <= '0;
            clk_q <= 1'b0;
            if (run_ok) begin
              state_q <= StRun;
            end else if (step_sel && step_rise) begin
              state_q <= StStepHi;
              clk_q   <= 1'b1;
              tick_q  <= 1'b1;
            end
          end
          StRun: begin
            if (!run_ok && !clk_q) begin
              // Stop while low: hold low, no runt pulse
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (half_done) begin
              cnt_q  <= '0;
              clk_q  <= ~clk_q;
              tick_q <= ~clk_q;
              if (!run_ok) begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (!run_ok) begin
                state_q <= StStopping;
              end
            end
          end
          StStopping: begin
            if (half_done) begin
              cnt_q   <= '0;
              clk_q   <= 1'b0;
              state_q <= run_ok ? StRun : StIdle;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= run_ok ? StRun : StStopping;
            end
          end
          StStepHi: begin
            if (half_done) begin
              cnt_q   <= '0;
              clk_q   <= 1'b0;
              state_q <= StStepLo;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StStepLo: begin
            if (half_done) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end

    assign clk_out[i]                    = clk_q;
    assign tick[i]                       = tick_q;
    assign div_active[i*CNT_W +: CNT_W]  = div_q;
  end

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: directed scenarios plus a randomized run compared
// against a half-period countdown model.
module tb_clock_gen;

  logic        clk_board = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_en = 2'b00;
  logic [1:0]  div_load = 2'b00;
  logic [63:0] div_value = '0;
  logic        step_mode = 1'b0;
  logic        step_req = 1'b0;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [63:0] div_active;

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0]  lv [0:300];
  logic [1:0]  tk [0:300];
  logic [63:0] dv [0:300];

  // Model: per channel, output level, busy flag, cycles left in the current half,
  // half-periods left for a step (-1 = free running), divisor and pending divisor.
  int          m_lvl [2];
  int          m_busy [2];
  int          m_left [2];
  int          m_halves [2];
  int          m_tick [2];
  int          m_pend_v [2];
  logic [31:0] m_div [2];
  logic [31:0] m_pend [2];
  bit          m_prev_step;

  clock_gen #(
    .NUM_CH(2),
    .CNT_W(32),
    .DIV_RESET({32'd5, 32'd50})
  ) dut (
    .clk_board(clk_board),
    .rst(rst),
    .ch_en(ch_en),
    .div_load(div_load),
    .div_value(div_value),
    .step_mode(step_mode),
    .step_req(step_req),
    .clk_out(clk_out),
    .tick(tick),
    .div_active(div_active)
  );

  always #5 clk_board = ~clk_board;

  function automatic int eff(input logic [31:0] d);
    return (d == 32'd0) ? 1 : int'(d);
  endfunction

  task automatic model_update();
    bit rise;
    rise = step_req && !m_prev_step;
    m_prev_step = rst ? 1'b0 : step_req;
    for (int c = 0; c < 2; c++) begin
      logic [31:0] ld;
      bit load, stepsel, want, consumed;
      ld = div_value[c*32 +: 32];
      load = div_load[c];
      stepsel = (c == 0) && step_mode;
      want = ch_en[c] && !stepsel;
      consumed = 0;
      if (rst) begin
        m_lvl[c] = 0; m_busy[c] = 0; m_left[c] = 0; m_halves[c] = -1; m_tick[c] = 0;
        m_div[c] = (c == 0) ? 32'd50 : 32'd5;
        m_pend_v[c] = 0;
      end else begin
        m_tick[c] = 0;
        if (m_busy[c] == 0) begin
          if (m_pend_v[c] != 0) begin
            m_div[c] = m_pend[c];
            m_pend_v[c] = 0;
          end
          if (want) begin
            m_busy[c] = 1; m_halves[c] = -1; m_left[c] = eff(m_div[c]);
          end else if (stepsel && rise) begin
            m_busy[c] = 1; m_halves[c] = 2; m_lvl[c] = 1; m_tick[c] = 1;
            m_left[c] = eff(m_div[c]);
          end
        end else if (m_halves[c] < 0 && !want && m_lvl[c] == 0) begin
          m_busy[c] = 0;
        end else begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            if (load) begin
              m_div[c] = ld; consumed = 1; m_pend_v[c] = 0;
            end else if (m_pend_v[c] != 0) begin
              m_div[c] = m_pend[c]; m_pend_v[c] = 0;
            end
            if (m_halves[c] > 0) begin
              m_halves[c]--;
              m_lvl[c] = 0;
              if (m_halves[c] == 0) m_busy[c] = 0;
            end else begin
              m_lvl[c] = (m_lvl[c] == 0) ? 1 : 0;
              m_tick[c] = m_lvl[c];
              if (!want && m_lvl[c] == 0) m_busy[c] = 0;
            end
            m_left[c] = eff(m_div[c]);
          end
        end
        if (load && !consumed) begin
          m_pend[c] = ld;
          m_pend_v[c] = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_board);
    model_update();
    #1;
  endtask

  task automatic rec(input int k);
    lv[k] = clk_out;
    tk[k] = tick;
    dv[k] = div_active;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_en = 2'b00; div_load = 2'b00; step_mode = 1'b0; step_req = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (clk_out !== 2'b00) begin n_fail++; $display("FAIL reset_clk_out: got %b want 00", clk_out); end
    n_checks++; if (tick !== 2'b00) begin n_fail++; $display("FAIL reset_tick: got %b want 00", tick); end
    n_checks++; if (div_active !== {32'd5, 32'd50}) begin n_fail++; $display("FAIL reset_div_active: got %h want %h", div_active, {32'd5, 32'd50}); end
  endtask

  task automatic test_run();
    int first0, first1, last0, last1, n0, n1, bad_int, bad_tick, hi1;
    logic [1:0] prev;
    first0 = -1; first1 = -1; last0 = 0; last1 = 0; n0 = 0; n1 = 0;
    bad_int = 0; bad_tick = 0; hi1 = 0;
    do_reset();
    ch_en = 2'b11;
    prev = clk_out;
    for (int k = 1; k <= 210; k++) begin
      cycle();
      for (int c = 0; c < 2; c++) begin
        if (tick[c] !== (clk_out[c] && !prev[c])) bad_tick++;
      end
      if (tick[1]) begin
        if (first1 < 0) first1 = k; else if (k - last1 != 10) bad_int++;
        last1 = k; n1++;
      end
      if (tick[0]) begin
        if (first0 < 0) first0 = k; else if (k - last0 != 100) bad_int++;
        last0 = k; n0++;
      end
      if (k >= 6 && k <= 205 && clk_out[1]) hi1++;
      prev = clk_out;
    end
    n_checks++; if (first1 !== 6) begin n_fail++; $display("FAIL run_first_rise_ch1: got %0d want 6", first1); end
    n_checks++; if (first0 !== 51) begin n_fail++; $display("FAIL run_first_rise_ch0: got %0d want 51", first0); end
    n_checks++; if (n1 !== 21) begin n_fail++; $display("FAIL run_ticks_ch1: got %0d want 21", n1); end
    n_checks++; if (n0 !== 2) begin n_fail++; $display("FAIL run_ticks_ch0: got %0d want 2", n0); end
    n_checks++; if (bad_int !== 0) begin n_fail++; $display("FAIL run_period: got %0d bad intervals want 0", bad_int); end
    n_checks++; if (bad_tick !== 0) begin n_fail++; $display("FAIL run_tick_on_rise: got %0d mismatches want 0", bad_tick); end
    n_checks++; if (hi1 !== 100) begin n_fail++; $display("FAIL run_duty_ch1: got %0d high cycles want 100", hi1); end
  endtask

  task automatic test_load();
    do_reset();
    ch_en = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      rec(k);
      if (k == 7) begin div_value = {32'd3, 32'd0}; div_load = 2'b10; end
      if (k == 8) div_load = 2'b00;
    end
    n_checks++; if (lv[6][1] !== 1'b1) begin n_fail++; $display("FAIL load_first_rise: got %b want 1", lv[6][1]); end
    n_checks++; if (dv[10][63:32] !== 32'd5) begin n_fail++; $display("FAIL load_old_div: got %0d want 5", dv[10][63:32]); end
    n_checks++; if ({lv[10][1], lv[11][1]} !== 2'b10) begin n_fail++; $display("FAIL load_old_half: got %b want 10", {lv[10][1], lv[11][1]}); end
    n_checks++; if (dv[11][63:32] !== 32'd3) begin n_fail++; $display("FAIL load_applied: got %0d want 3", dv[11][63:32]); end
    n_checks++; if ({lv[13][1], lv[14][1], tk[14][1]} !== 3'b011) begin n_fail++; $display("FAIL load_new_low: got %b want 011", {lv[13][1], lv[14][1], tk[14][1]}); end
    n_checks++; if ({lv[16][1], lv[17][1]} !== 2'b10) begin n_fail++; $display("FAIL load_new_high: got %b want 10", {lv[16][1], lv[17][1]}); end
    n_checks++; if (dv[11][31:0] !== 32'd50) begin n_fail++; $display("FAIL load_ch0_untouched: got %0d want 50", dv[11][31:0]); end
  endtask

  task automatic test_zero();
    int same, nt;
    same = 0; nt = 0;
    do_reset();
    div_value = '0; div_load = 2'b10;
    cycle();
    div_load = 2'b00;
    cycle();
    cycle();
    n_checks++; if (div_active[63:32] !== 32'd0) begin n_fail++; $display("FAIL zero_div_active: got %0d want 0", div_active[63:32]); end
    ch_en = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      rec(k);
      if (tk[k][1]) nt++;
      if (k >= 3 && lv[k][1] === lv[k-1][1]) same++;
    end
    n_checks++; if ({lv[1][1], lv[2][1], tk[2][1]} !== 3'b011) begin n_fail++; $display("FAIL zero_first_rise: got %b want 011", {lv[1][1], lv[2][1], tk[2][1]}); end
    n_checks++; if (same !== 0) begin n_fail++; $display("FAIL zero_alternate: got %0d repeats want 0", same); end
    n_checks++; if (nt !== 10) begin n_fail++; $display("FAIL zero_ticks: got %0d want 10", nt); end
  endtask

  task automatic test_stop();
    int late_ticks, late_hi, hi;
    late_ticks = 0; late_hi = 0; hi = 0;
    do_reset();
    ch_en = 2'b01;
    for (int k = 1; k <= 260; k++) begin
      cycle();
      rec(k);
      if (k == 60) ch_en = 2'b00;
      if (k >= 52 && tk[k][0]) late_ticks++;
      if (k >= 101 && lv[k][0]) late_hi++;
      if (k >= 51 && k <= 100 && lv[k][0]) hi++;
    end
    n_checks++; if ({lv[51][0], tk[51][0]} !== 2'b11) begin n_fail++; $display("FAIL stop_rise: got %b want 11", {lv[51][0], tk[51][0]}); end
    n_checks++; if ({lv[100][0], lv[101][0]} !== 2'b10) begin n_fail++; $display("FAIL stop_fall_time: got %b want 10", {lv[100][0], lv[101][0]}); end
    n_checks++; if (hi !== 50) begin n_fail++; $display("FAIL stop_high_len: got %0d want 50", hi); end
    n_checks++; if (late_ticks !== 0) begin n_fail++; $display("FAIL stop_no_ticks: got %0d want 0", late_ticks); end
    n_checks++; if (late_hi !== 0) begin n_fail++; $display("FAIL stop_held_low: got %0d want 0", late_hi); end
  endtask

  task automatic test_step();
    int hi, nt, hi1;
    hi = 0; nt = 0; hi1 = 0;
    do_reset();
    step_mode = 1'b1; ch_en = 2'b01; step_req = 1'b1;
    for (int k = 1; k <= 115; k++) begin
      cycle();
      rec(k);
      if (k == 20) step_req = 1'b0;
      if (k == 29) step_req = 1'b1;
      if (k == 39) step_req = 1'b0;
      if (k == 110) step_req = 1'b1;
      if (k <= 110 && lv[k][0]) hi++;
      if (k <= 110 && tk[k][0]) nt++;
      if (lv[k][1]) hi1++;
    end
    n_checks++; if ({lv[1][0], tk[1][0]} !== 2'b11) begin n_fail++; $display("FAIL step_start: got %b want 11", {lv[1][0], tk[1][0]}); end
    n_checks++; if ({lv[50][0], lv[51][0]} !== 2'b10) begin n_fail++; $display("FAIL step_fall: got %b want 10", {lv[50][0], lv[51][0]}); end
    n_checks++; if (hi !== 50) begin n_fail++; $display("FAIL step_one_period: got %0d high want 50", hi); end
    n_checks++; if (nt !== 1) begin n_fail++; $display("FAIL step_one_tick: got %0d want 1", nt); end
    n_checks++; if ({lv[111][0], tk[111][0]} !== 2'b11) begin n_fail++; $display("FAIL step_next_edge: got %b want 11", {lv[111][0], tk[111][0]}); end
    n_checks++; if (hi1 !== 0) begin n_fail++; $display("FAIL step_ch1_idle: got %0d want 0", hi1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_en = 2'b11;
    for (int k = 1; k <= 55; k++) begin
      cycle();
      if (k == 2) begin div_value = {32'd7, 32'd0}; div_load = 2'b10; end
      if (k == 3) div_load = 2'b00;
    end
    n_checks++; if (clk_out[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_high: got %b want 1", clk_out[0]); end
    n_checks++; if (div_active[63:32] !== 32'd7) begin n_fail++; $display("FAIL mid_pre_div: got %0d want 7", div_active[63:32]); end
    rst = 1'b1;
    cycle();
    n_checks++; if ({clk_out, tick} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_outputs: got %b want 0000", {clk_out, tick}); end
    n_checks++; if (div_active !== {32'd5, 32'd50}) begin n_fail++; $display("FAIL mid_rst_div: got %h want %h", div_active, {32'd5, 32'd50}); end
    rst = 1'b0; ch_en = 2'b00;
    cycle(); cycle(); cycle();
    n_checks++; if (clk_out !== 2'b00) begin n_fail++; $display("FAIL mid_idle_after: got %b want 00", clk_out); end
  endtask

  task automatic test_random();
    logic [1:0]  ec, et;
    logic [63:0] ed;
    int bad_clk, bad_tick, bad_div;
    bad_clk = 0; bad_tick = 0; bad_div = 0;
    do_reset();
    div_value = {32'd3, 32'd4}; div_load = 2'b11; ch_en = 2'b11;
    for (int k = 0; k < 1500; k++) begin
      cycle();
      for (int c = 0; c < 2; c++) begin
        ec[c] = m_lvl[c][0];
        et[c] = m_tick[c][0];
        ed[c*32 +: 32] = m_div[c];
      end
      if (clk_out !== ec) begin bad_clk++; $display("FAIL rand_clk_out @%0d: got %b want %b", k, clk_out, ec); end
      if (tick !== et) begin bad_tick++; $display("FAIL rand_tick @%0d: got %b want %b", k, tick, et); end
      if (div_active !== ed) begin bad_div++; $display("FAIL rand_div_active @%0d: got %h want %h", k, div_active, ed); end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, 1)] ^= 1'b1;
      div_load = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      div_value = {32'($urandom_range(0, 7)), 32'($urandom_range(0, 9))};
      if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 7) == 0) step_req = ~step_req;
    end
    n_checks++; if (bad_clk !== 0) begin n_fail++; $display("FAIL rand_clk_total: got %0d mismatching cycles want 0", bad_clk); end
    n_checks++; if (bad_tick !== 0) begin n_fail++; $display("FAIL rand_tick_total: got %0d mismatching cycles want 0", bad_tick); end
    n_checks++; if (bad_div !== 0) begin n_fail++; $display("FAIL rand_div_total: got %0d mismatching cycles want 0", bad_div); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load();
    test_zero();
    test_stop();
    test_step();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
